div_ctrl: RTL and testbench
===========================

// Module: div_ctrl
// PURPOSE
//  Multi-cycle radix-2 restoring divider with its own sequencing FSM; serves DIV/DIVU for the EX stage.
//  EX holds start_i high and stalls the pipeline until ready_o; HI/LO then take result_o (HI=remainder, LO=quotient).
//  Fixed 32 iterations; divide-by-zero short path; annul_i aborts an in-flight op (flush/exception).
// PARAMETERS
//  DATA_W  32  operand width; result_o is 2*DATA_W; iteration count = DATA_W
// PORTS
//  clk           in   1         clock, all state updates on posedge
//  rst           in   1         synchronous, active-high reset (one clock; reset is synchronous and active-high)
//  signed_div_i  in   1         1=DIV (two's complement), 0=DIVU
//  opdata1_i     in   DATA_W    dividend, sampled only on FREE->ON/BYZERO transition
//  opdata2_i     in   DATA_W    divisor, sampled same edge
//  start_i       in   1         request; held high by EX until it has consumed ready_o
//  annul_i       in   1         abort current op; dominates start_i
//  result_o      out  2*DATA_W  {remainder, quotient}; valid only while ready_o=1, else 0
//  ready_o       out  1         registered; 1 exactly while FSM in END
// BEHAVIOUR
//  Reset: state=FREE, cnt=0, result_o=0, ready_o=0, internal dividend/divisor regs=0; rst mid-op discards op.
//  FSM states (2b, in defines.v): FREE, BYZERO, ON, END.
//  FREE: start_i&!annul_i & opdata2_i==0 -> BYZERO; start_i&!annul_i & opdata2_i!=0 -> ON, cnt<=0,
//    latch |op1|,|op2| (abs only if signed_div_i & msb=1), latch sign(op1), sign(op1)^sign(op2), signed flag;
//    working reg {33'b0, |op1|, 1'b0}-style: 65-bit {rem, quot} shift register.
//  ON, per cycle: diff = rem[32:0] - {1'b0,|op2|}; if diff[32]=1 shift in 0 else rem<=diff, shift in 1; cnt++.
//    When cnt==DATA_W: apply sign fixups, result_o<={rem,quot}, ready_o<=1, -> END (no extra iteration).
//    annul_i=1 in ON -> FREE, cnt<=0, ready_o stays 0; no result produced.
//  Sign fixups (signed only): quot negated if operand signs differ; rem negated if dividend negative.
//    0x80000000 / 0xFFFFFFFF signed -> quot=0x80000000, rem=0 (wraps, no trap).
//  BYZERO: next cycle -> END with result_o=0 (decided value for /0), ready_o<=1. annul_i -> FREE.
//  END: hold result_o/ready_o while start_i=1; start_i=0 -> FREE, result_o<=0, ready_o<=0 next edge.
//    annul_i in END -> FREE likewise. A new start is only accepted from FREE (>=1 cycle gap).
//  Latency: start_i first sampled at edge 0 -> ready_o high after edge DATA_W+1 (33 for 32b); /0 after edge 1.
//  Operands ignored outside FREE; changing them mid-op has no effect.
//  Widths: cnt is $clog2(DATA_W)+1 bits; subtract is DATA_W+1 bits; no overflow flag output.
// STRUCTURE
//  defines.v: DivFree/DivByZero/DivOn/DivEnd, DivResultReady/NotReady, DivStart/DivStop (shared with ex).
//  Single module: FSM + counter + 65-bit shift reg + sign fixup; one combinational sub-module
//  div_step (DATA_W+1 subtract/compare, outputs next rem and quotient bit) is natural and reused by FV.
// TESTING
//  DIVU 100/7, start held -> ready_o rises after edge 33, result_o=0x00000002_0000000E, held until start drops.
//  DIV -7/2 -> result_o=0xFFFFFFFF_FFFFFFFD; DIV 7/-2 -> 0x00000001_FFFFFFFD.
//  DIV 0x80000000/0xFFFFFFFF -> result_o=0x00000000_80000000; DIVU same -> 0x80000000_00000000.
//  DIVU 5/0 -> ready_o after edge 1, result_o=0; start low -> FREE, ready_o=0 next cycle.
//  annul_i at cnt=10 -> FREE, ready_o never rises; immediate new DIVU 9/3 -> 0x00000000_00000003 on schedule.
//  rst pulsed at cnt=20 -> all outputs 0 next edge; operand change during ON leaves result unaffected.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the EX-stage divider: FSM state encoding and handshake levels.
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_ctrl_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_ctrl_step
    import div_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem_i,
    input  logic              shift_in_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] rem_o,
    output logic              quot_bit_o
);

    logic [DATA_W:0] partial;
    logic [DATA_W:0] diff;

    // partial < 2*divisor, so a set msb of the DATA_W+1 bit difference means "divisor did not fit"
    always_comb begin
        partial    = {rem_i, shift_in_i};
        diff       = partial - {1'b0, divisor_i};
        quot_bit_o = ~diff[DATA_W];
        rem_o      = diff[DATA_W] ? partial[DATA_W-1:0] : diff[DATA_W-1:0];
    end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) with its own sequencing FSM for the EX stage.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   quot_q, quot_d;
    logic [DATA_W-1:0]   divisor_q, divisor_d;
    logic                neg_quot_q, neg_quot_d;
    logic                neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;

    logic [DATA_W-1:0]   step_rem;
    logic                step_qbit;

    function automatic logic [DATA_W-1:0] cond_neg(input logic signed [DATA_W-1:0] v,
                                                   input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                    input logic is_signed);
        return cond_neg(v, is_signed & v[DATA_W-1]);
    endfunction

    div_ctrl_step #(.DATA_W(DATA_W)) u_step (
        .rem_i      (rem_q),
        .shift_in_i (quot_q[DATA_W-1]),
        .divisor_i  (divisor_q),
        .rem_o      (step_rem),
        .quot_bit_o (step_qbit)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        unique case (state_q)
            DIV_FREE: begin
                if (start_i == DIV_START && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = DIV_BYZERO;
                    end else begin
                        state_d    = DIV_ON;
                        cnt_d      = '0;
                        rem_d      = '0;
                        quot_d     = magnitude(opdata1_i, signed_div_i);
                        divisor_d  = magnitude(opdata2_i, signed_div_i);
                        neg_quot_d = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        neg_rem_d  = signed_div_i & opdata1_i[DATA_W-1];
                    end
                end
            end
            DIV_BYZERO: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else begin
                    state_d  = DIV_END;
                    result_d = '0;
                    ready_d  = DIV_RESULT_READY;
                end
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(DATA_W)) begin
                    // Magnitudes are done; restore signs (MIN/-1 wraps back to MIN)
                    state_d  = DIV_END;
                    result_d = {cond_neg(rem_q, neg_rem_q), cond_neg(quot_q, neg_quot_q)};
                    ready_d  = DIV_RESULT_READY;
                end else begin
                    rem_d  = step_rem;
                    quot_d = {quot_q[DATA_W-2:0], step_qbit};
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            DIV_END: begin
                if (annul_i || start_i == DIV_STOP) begin
                    state_d  = DIV_FREE;
                    result_d = '0;
                    ready_d  = DIV_RESULT_NOT_READY;
                end
            end
            default: state_d = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DIV_FREE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= DIV_RESULT_NOT_READY;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: directed divisions, latency, hold, /0, annul and reset cases.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic ready_prev = 1'b0;

    div_ctrl #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per rising ready and checks value and arrival cycle
    always @(negedge clk) begin
        if (ready === 1'b1 && ready_prev !== 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready: got result %h at cycle %0d, required no result", result, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("result", result, mon_e.res);
                chk("latency", 64'(cyc), 64'(mon_e.cyc));
            end
        end
        if (ready !== 1'b1) chk("idle_zero", result, 64'd0);
        ready_prev <= ready;
    end

    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int lat);
        @(negedge clk);
        signed_div = sgn;
        op1        = a;
        op2        = b;
        start      = 1'b1;
        sb.push_back('{exp, cyc + 1 + lat});
    endtask

    task automatic finish_op(input string name, input logic [63:0] exp);
        for (int i = 0; i < 60 && ready !== 1'b1; i++) @(negedge clk);
        chk({name, "_ready"}, 64'(ready), 64'd1);
        repeat (3) begin
            @(negedge clk);
            chk({name, "_hold"}, result, exp);
            chk({name, "_hold_ready"}, 64'(ready), 64'd1);
        end
        start = 1'b0;
        @(negedge clk);
        chk({name, "_drop_ready"}, 64'(ready), 64'd0);
        chk({name, "_drop_result"}, result, 64'd0);
    endtask

    task automatic do_op(input string name, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input bit scramble);
        issue(sgn, a, b, exp, (b == 32'd0) ? 1 : 33);
        if (scramble) begin
            @(negedge clk);
            op1        = $urandom;
            op2        = $urandom;
            signed_div = ~sgn;
        end
        finish_op(name, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        signed_div = 1'b0;
        op1        = '0;
        op2        = '0;
        start      = 1'b0;
        annul      = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 64'(ready), 64'd0);
        chk("reset_result", result, 64'd0);
        rst = 1'b0;

        do_op("divu_100_7",    1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 1'b0);
        do_op("div_m7_2",      1'b1, 32'hFFFFFFF9,   32'd2,        64'hFFFFFFFF_FFFFFFFD, 1'b0);
        do_op("div_7_m2",      1'b1, 32'd7,          32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0);
        do_op("div_min_m1",    1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000, 1'b0);
        do_op("divu_min_max",  1'b0, 32'h80000000,   32'hFFFFFFFF, 64'h80000000_00000000, 1'b0);
        do_op("divu_5_0",      1'b0, 32'd5,          32'd0,        64'h0,                 1'b0);
        do_op("div_m100_0",    1'b1, 32'hFFFFFF9C,   32'd0,        64'h0,                 1'b0);
        do_op("divu_max_1",    1'b0, 32'hFFFFFFFF,   32'd1,        64'h00000000_FFFFFFFF, 1'b0);
        do_op("divu_3_10",     1'b0, 32'd3,          32'd10,       64'h00000003_00000000, 1'b0);
        do_op("divu_100_7_sc", 1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 1'b1);
        do_op("div_m100_7_sc", 1'b1, 32'hFFFFFF9C,   32'd7,        64'hFFFFFFFE_FFFFFFF2, 1'b1);

        // Abort at cnt=10 with start still high, then a fresh op from FREE
        @(negedge clk);
        signed_div = 1'b0;
        op1        = 32'd1000;
        op2        = 32'd7;
        start      = 1'b1;
        repeat (11) @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        chk("annul_ready", 64'(ready), 64'd0);
        op1 = 32'd9;
        op2 = 32'd3;
        sb.push_back('{64'h00000000_00000003, cyc + 1 + 33});
        finish_op("divu_9_3_after_annul", 64'h00000000_00000003);

        // Reset mid-op discards the operation entirely
        issue(1'b0, 32'd50000, 32'd3, 64'h0, 33);
        void'(sb.pop_back());
        repeat (21) @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk("midop_rst_ready", 64'(ready), 64'd0);
        chk("midop_rst_result", result, 64'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("post_rst_ready", 64'(ready), 64'd0);

        do_op("divu_after_rst", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 1'b0);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
